// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among
//               NUM_REQ byte-stream requesters. A requester keeps the grant
//               for a burst ending on its last byte, when its valid drops,
//               or after MAX_BURST bytes. Each byte is passed through the
//               transmitter's busy handshake so requesters never see baud
//               timing.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               req_valid/data/last - per-requester byte stream (data packed
//                                 8 bits per requester)
//               req_ready       - one-hot single-cycle byte acceptance
//               grant, owner    - current owner (one-hot / index)
//               tx_data, tx_wr_en, tx_busy - transmitter write port
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16,
   parameter int IDX_W     = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_W-1:0]     owner,
   output logic [7:0]           tx_data,
   output logic                 tx_wr_en,
   input  logic                 tx_busy
);

   localparam int               CNT_W       = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
   localparam logic [IDX_W:0]   C_NUM_REQ   = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_ISSUE  = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               last_q;
   logic [7:0]         tx_data_q;
   logic               tx_wr_en_q;

   logic               win_found_d;
   logic [IDX_W-1:0]   win_idx_d;
   logic [NUM_REQ-1:0] win_onehot_d;
   logic [7:0]         sel_data_d;
   logic               sel_last_d;
   logic               sel_valid_d;
   logic [IDX_W-1:0]   rr_next_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               burst_end_d;

   // Round-robin search: candidate index = rr_ptr + k folded back into
   // 0..NUM_REQ-1 with a single subtract (both terms are < NUM_REQ).
   always_comb begin : p_search
      logic [IDX_W:0] cand;
      win_found_d = 1'b0;
      win_idx_d   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
         if (cand >= C_NUM_REQ) begin
            cand = cand - C_NUM_REQ;
         end
         if (!win_found_d && req_valid[cand[IDX_W-1:0]]) begin
            win_found_d = 1'b1;
            win_idx_d   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin : p_onehot
      win_onehot_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_onehot_d[i] = (win_idx_d == IDX_W'(i));
      end
   end

   // Owner's byte stream, selected with constant part-selects.
   always_comb begin : p_sel
      sel_data_d  = 8'h00;
      sel_last_d  = 1'b0;
      sel_valid_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            sel_data_d  = req_data[8*i +: 8];
            sel_last_d  = req_last[i];
            sel_valid_d = req_valid[i];
         end
      end
   end

   assign rr_next_d   = (owner_q == C_LAST_IDX) ? '0 : owner_q + 1'b1;
   // Saturating burst counter: it never wraps back below MAX_BURST.
   assign cnt_d       = (cnt_q == C_MAX_BURST) ? cnt_q : cnt_q + 1'b1;
   assign burst_end_d = last_q || (cnt_q == C_MAX_BURST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_wr_en_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_found_d) begin
                  owner_q <= win_idx_d;
                  grant_q <= win_onehot_d;
                  cnt_q   <= '0;
                  state_q <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (!sel_valid_d) begin
                  // Requester withdrew: release without issuing a byte.
                  grant_q  <= '0;
                  rr_ptr_q <= rr_next_d;
                  state_q  <= S_IDLE;
               end else if (!tx_busy) begin
                  tx_data_q  <= sel_data_d;
                  last_q     <= sel_last_d;
                  cnt_q      <= cnt_d;
                  tx_wr_en_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Hold the strobe until the transmitter shows it took the byte.
               if (tx_busy) begin
                  tx_wr_en_q <= 1'b0;
                  state_q    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!tx_busy) begin
                  if (burst_end_d) begin
                     grant_q  <= '0;
                     rr_ptr_q <= rr_next_d;
                     state_q  <= S_IDLE;
                  end else begin
                     state_q  <= S_ACCEPT;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Acceptance is only offered while the transmitter is free, so a byte is
   // never taken that cannot be issued right away.
   assign req_ready = ((state_q == S_ACCEPT) && sel_valid_d && !tx_busy) ? grant_q : '0;
   assign grant     = grant_q;
   assign owner     = owner_q;
   assign tx_data   = tx_data_q;
   assign tx_wr_en  = tx_wr_en_q;

endmodule
`default_nettype wire
